// File: rtl/w_bank_write_sched_pkg.sv
// Shared types and constants for the SRAM bank write scheduler.
package w_bank_write_sched_pkg;

    localparam int NUM_REQ   = 16;
    localparam int SEL_W     = 5;
    localparam int PTR_W     = 4;
    localparam int LEN_W_DEF = 8;

    // Out-of-range select parks the write mux with CEN=1 / WEN=1.
    localparam logic [SEL_W-1:0] SEL_IDLE = SEL_W'(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/w_bank_write_sched_rr_arbiter_16.sv
// Combinational rotate-priority encoder: first set request at or above the pointer, wrapping.
module rr_arbiter_16
    import w_bank_write_sched_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [PTR_W-1:0]   o_idx,
    output logic               o_found
);

    logic [PTR_W-1:0] w_cand;
    logic             w_found;
    logic [PTR_W-1:0] w_idx;

    // The 4-bit add wraps naturally at NUM_REQ-1 -> 0.
    always_comb begin
        w_cand  = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = i_ptr + PTR_W'(i);
            if (!w_found && i_req[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
    end

    assign o_found = w_found;
    assign o_idx   = w_idx;
    assign o_gnt   = w_found ? (NUM_REQ'(1) << w_idx) : '0;

endmodule

// File: rtl/w_bank_write_sched.sv
// Round-robin write scheduler for one SRAM bank write port shared by 16 lanes.
// Optional W_SCHED_STAT_EN adds saturating stall_cnt / grant_cnt outputs.
module w_bank_write_sched
    import w_bank_write_sched_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [LEN_W-1:0]   batch_len,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   sel_out,
    output logic               w_enable_out,
    output logic               busy,
    output logic               done,
`ifdef W_SCHED_STAT_EN
    output logic [15:0]        stall_cnt,
    output logic [15:0]        grant_cnt,
`endif
    output logic [1:0]         o_dbg_state
);

    state_e             r_state;
    state_e             w_next_state;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [LEN_W-1:0]   r_remain;

    logic [NUM_REQ-1:0] w_arb_gnt;
    logic [PTR_W-1:0]   w_arb_idx;
    logic               w_arb_found;
    logic               w_grant;
    logic               w_accept;

    rr_arbiter_16 u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_gnt   (w_arb_gnt),
        .o_idx   (w_arb_idx),
        .o_found (w_arb_found)
    );

    assign w_grant  = (r_state == ST_RUN) && w_arb_found;
    assign w_accept = (r_state == ST_IDLE) && start;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next_state = (batch_len != '0) ? ST_RUN : ST_FIN;
            ST_RUN:  if (w_grant && (r_remain == LEN_W'(1))) w_next_state = ST_FIN;
            ST_FIN:  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        gnt          = w_grant ? w_arb_gnt : '0;
        sel_out      = w_grant ? {1'b0, w_arb_idx} : SEL_IDLE;
        w_enable_out = w_grant;
        busy         = (r_state == ST_RUN);
        done         = (r_state == ST_FIN);
        o_dbg_state  = r_state;
    end

    // rr_ptr deliberately survives across batches; only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
            r_remain <= '0;
        end else if (w_accept && (batch_len != '0)) begin
            r_remain <= batch_len;
        end else if (w_grant) begin
            r_rr_ptr <= w_arb_idx + PTR_W'(1);
            r_remain <= r_remain - LEN_W'(1);
        end
    end

`ifdef W_SCHED_STAT_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_grant_cnt;

    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            r_stall_cnt <= '0;
            r_grant_cnt <= '0;
        end else begin
            if ((r_state == ST_RUN) && (req_valid == '0) && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 16'd1;
            if (w_grant && (r_grant_cnt != 16'hFFFF))
                r_grant_cnt <= r_grant_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign grant_cnt = r_grant_cnt;
`endif

endmodule

// File: tb/tb_w_bank_write_sched.sv
// Scoreboard bench: main process pushes expected grant lanes (16 = done pulse), monitor pops on each output event.
module tb_w_bank_write_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  batch_len = '0;
  logic [15:0] req_valid = '0;
  logic [15:0] gnt;
  logic [4:0]  sel_out;
  logic        w_enable_out;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;
`ifdef W_SCHED_STAT_EN
  logic [15:0] stall_cnt;
  logic [15:0] grant_cnt;
`endif

  int total = 0;
  int bad = 0;
  logic mon_en = 1'b0;
  logic [4:0] exp_q[$];
  logic [4:0] e;
  logic       ok;
  int         n;

  w_bank_write_sched dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .batch_len    (batch_len),
    .req_valid    (req_valid),
    .gnt          (gnt),
    .sel_out      (sel_out),
    .w_enable_out (w_enable_out),
    .busy         (busy),
    .done         (done),
`ifdef W_SCHED_STAT_EN
    .stall_cnt    (stall_cnt),
    .grant_cnt    (grant_cnt),
`endif
    .o_dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // monitor: every grant or done pulse must match the head of the expected queue
  always @(negedge clk) begin
    if (mon_en && (w_enable_out === 1'b1 || done === 1'b1)) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: got sel=%0d gnt=%h done=%0b, expected no event", sel_out, gnt, done);
      end else begin
        e = exp_q.pop_front();
        if (e == 5'd16)
          ok = (done === 1'b1) && (w_enable_out === 1'b0) && (gnt === 16'h0) && (sel_out === 5'd16);
        else
          ok = (done === 1'b0) && (w_enable_out === 1'b1) && (sel_out === e) && (gnt === (16'd1 << e));
        if (!ok) begin
          bad++;
          $display("FAIL event: got sel=%0d gnt=%h wen=%0b done=%0b, expected %s %0d",
                   sel_out, gnt, w_enable_out, done, (e == 5'd16) ? "done" : "lane", e);
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endtask

  task automatic drain(input int max_cycles, output int cycles);
    cycles = 0;
    while (exp_q.size() != 0 && cycles < max_cycles) begin
      tick();
      cycles++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: got %0d pending events, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic kick(input logic [7:0] len);
    start = 1'b1;
    batch_len = len;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // 1. reset with all lanes requesting
    req_valid = 16'hFFFF;
    do_reset();
    rst = 1'b1;
    check("reset_gnt", 32'(gnt), 32'h0);
    check("reset_sel", 32'(sel_out), 32'd16);
    check("reset_wen", 32'(w_enable_out), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    // 2. full rotation, 20 writes, no bubbles
    for (int i = 0; i < 20; i++) exp_q.push_back(5'(i % 16));
    exp_q.push_back(5'd16);
    kick(8'd20);
    check("rot_busy", 32'(busy), 32'd1);
    drain(100, n);
    check("rot_cycles", 32'(n), 32'd21);
    exp_q.push_back(5'd4);
    exp_q.push_back(5'd16);
    kick(8'd1);
    drain(20, n);
    tick();

    // 3. sparse requests from rr_ptr=0
    req_valid = 16'h8101;
    do_reset();
    exp_q.push_back(5'd0);
    exp_q.push_back(5'd8);
    exp_q.push_back(5'd15);
    exp_q.push_back(5'd16);
    kick(8'd3);
    drain(50, n);
    check("sparse_cycles", 32'(n), 32'd4);
    req_valid = 16'h0;
    tick();

    // 4. stall then lane 5 twice; rr_ptr is 0 here
    exp_q.push_back(5'd5);
    exp_q.push_back(5'd5);
    exp_q.push_back(5'd16);
    kick(8'd2);
    for (int i = 0; i < 5; i++) begin
      check("stall_busy", 32'(busy), 32'd1);
      check("stall_wen", 32'(w_enable_out), 32'd0);
      tick();
    end
    req_valid = 16'h0020;
    drain(20, n);
    check("stall_grant_cycles", 32'(n), 32'd3);
    req_valid = 16'h0;
`ifdef W_SCHED_STAT_EN
    check("stall_cnt", 32'(stall_cnt), 32'd5);
    check("grant_cnt", 32'(grant_cnt), 32'd2);
`endif
    tick();

    // 5. zero-length batch, then a start during RUN that must be ignored
    req_valid = 16'hFFFF;
    exp_q.push_back(5'd16);
    kick(8'd0);
    drain(10, n);
    check("zero_len_cycles", 32'(n), 32'd1);
    tick();
    req_valid = 16'h0;
    for (int i = 6; i < 9; i++) exp_q.push_back(5'(i));
    exp_q.push_back(5'd16);
    kick(8'd3);
    start = 1'b1;
    batch_len = 8'd9;
    tick();
    start = 1'b0;
    req_valid = 16'hFFFF;
    drain(20, n);
    check("ignored_start_cycles", 32'(n), 32'd4);
    tick();

    // 6. reset after 3 of 10 writes; rr_ptr is 9 here
    exp_q.push_back(5'd9);
    exp_q.push_back(5'd10);
    exp_q.push_back(5'd11);
    kick(8'd10);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_sel", 32'(sel_out), 32'd16);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_pending", 32'(exp_q.size()), 32'd0);
    tick();
    tick();
    tick();
    exp_q.push_back(5'd0);
    exp_q.push_back(5'd16);
    kick(8'd1);
    drain(20, n);
    tick();
    tick();

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
